// File: rtl/mod_arith_pkg.sv
// -----------------------------------------------------------------------------
// mod_arith_pkg
// Shared types and helpers for the modular-arithmetic datapath stages.
//   mod_mul_state_t : control states of the sequential modular multiplier
//   mod_word_t      : wide working word (MAX_W + 2 bits) for reduction steps
//   mod_dbl_add()   : one interleaved step, (2*acc + bit*a) mod m
// -----------------------------------------------------------------------------
package mod_arith_pkg;

    // Widest operand width supported by the helpers below.
    localparam int unsigned MAX_W = 32;

    // Two guard bits: 2*acc < 2*MOD and (2*acc mod MOD) + a < 2*MOD.
    typedef logic [MAX_W+1:0] mod_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mod_mul_state_t;

    // Requires acc < m and a < m; the result is then also < m.
    function automatic mod_word_t mod_dbl_add(
        input mod_word_t acc,
        input mod_word_t a,
        input logic      mbit,
        input mod_word_t m
    );
        mod_word_t t;
        t = acc << 1;
        if (t >= m) begin
            t = t - m;
        end
        if (mbit) begin
            t = t + a;
            if (t >= m) begin
                t = t - m;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/mod_mul_seq_if.sv
// -----------------------------------------------------------------------------
// mod_mul_seq_if
// Operand/result streaming bundle of the sequential modular multiplier.
//   in_valid  / in_ready  : operand handshake (source -> multiplier)
//   in_a, in_b            : multiplicand, multiplier (W bits)
//   out_valid / out_ready : result handshake (multiplier -> sink)
//   out_z                 : (a*b) mod MOD, 0 on range error
//   out_err               : operand out of range
// Modports: master = operand source / result sink, slave = multiplier.
// -----------------------------------------------------------------------------
interface mod_mul_seq_if #(
    parameter int unsigned W = 6
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_z;
    logic         out_err;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_z, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_z, out_err
    );
endinterface

// File: rtl/mod_step.sv
// -----------------------------------------------------------------------------
// mod_step
// Combinational interleaved modular step: o_acc = (2*i_acc + i_bit*i_a) mod MOD.
// Ports:
//   i_acc  in  W  running accumulator, < MOD
//   i_a    in  W  multiplicand, < MOD
//   i_bit  in  1  current multiplier bit
//   o_acc  out W  next accumulator, < MOD
// -----------------------------------------------------------------------------
module mod_step
    import mod_arith_pkg::*;
#(
    parameter int unsigned W   = 6,
    parameter int unsigned MOD = 53
) (
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_a,
    input  logic         i_bit,
    output logic [W-1:0] o_acc
);

    assign o_acc = W'(mod_dbl_add(mod_word_t'(i_acc), mod_word_t'(i_a),
                                  i_bit, mod_word_t'(MOD)));

endmodule

// File: rtl/mod_mul_seq.sv
// -----------------------------------------------------------------------------
// mod_mul_seq
// Sequential modular multiplier, z = (a * b) mod MOD, one multiplier bit per
// clock, MSB first. Either a constant multiplier (USE_CONST=1, CONST_B) or a
// runtime multiplier taken from in_b.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   bus    slave modport of mod_mul_seq_if (operand and result streams)
// Timing: accept at edge E -> out_valid high after edge E+W; result held
// until out_ready; a new job may be accepted on the result handshake edge.
// -----------------------------------------------------------------------------
module mod_mul_seq
    import mod_arith_pkg::*;
#(
    parameter int unsigned MOD       = 53,
    parameter int unsigned W         = 6,
    parameter int unsigned USE_CONST = 1,
    parameter int unsigned CONST_B   = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    mod_mul_seq_if.slave  bus
);

    localparam int unsigned  CW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [W-1:0] MOD_W = W'(MOD);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (W < 1 || W > MAX_W) begin : g_bad_w
        $error("mod_mul_seq: W=%0d outside 1..%0d", W, MAX_W);
    end
    if (64'(MOD) >= (64'(1) << W) || MOD < 2) begin : g_bad_mod
        $error("mod_mul_seq: MOD=%0d must satisfy 2 <= MOD < 2**W (W=%0d)", MOD, W);
    end
    if (CONST_B >= MOD) begin : g_bad_const
        $error("mod_mul_seq: CONST_B=%0d must be < MOD=%0d", CONST_B, MOD);
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    mod_mul_state_t r_state;
    mod_mul_state_t w_next_state;

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_err;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_out_valid;
    logic [W-1:0]  r_out_z;
    logic          r_out_err;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_last;
    logic          w_bit;
    logic          w_in_err;
    logic [W-1:0]  w_in_b;
    logic [W-1:0]  w_step_acc;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_last       = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // Result handshake doubles as the accept slot for the next job.
                w_in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    w_next_state = bus.in_valid ? BUSY : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        w_accept = w_in_ready & bus.in_valid;
    end

    // ------------------------------------------------------------------
    // Operand selection and range check at accept
    // ------------------------------------------------------------------
    assign w_in_b   = (USE_CONST != 0) ? W'(CONST_B) : bus.in_b;
    assign w_in_err = (bus.in_a >= MOD_W) ||
                      ((USE_CONST == 0) && (bus.in_b >= MOD_W));

    // ------------------------------------------------------------------
    // Reduction step
    // ------------------------------------------------------------------
    assign w_bit = r_b[r_cnt];

    mod_step #(
        .W   (W),
        .MOD (MOD)
    ) u_step (
        .i_acc (r_acc),
        .i_a   (r_a),
        .i_bit (w_bit),
        .o_acc (w_step_acc)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_err       <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_z     <= '0;
            r_out_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= bus.in_a;
                r_b   <= w_in_b;
                r_err <= w_in_err;
                r_acc <= '0;
                r_cnt <= CW'(W - 1);
            end else if (r_state == BUSY) begin
                r_acc <= w_step_acc;
                r_cnt <= r_cnt - CW'(1);
            end

            // Erroneous operands still run the full W steps so latency
            // stays constant; only the published result is suppressed.
            if (w_last) begin
                r_out_valid <= 1'b1;
                r_out_z     <= r_err ? '0 : w_step_acc;
                r_out_err   <= r_err;
            end else if (r_state == DONE && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_z     = r_out_z;
    assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_mod_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mod_mul_seq
// Three multipliers side by side: constant K=13 mod 53 (W=6), runtime mod 53
// (W=6) and runtime mod 251 (W=8). Results are compared with plain
// (a*b) % MOD arithmetic including the operand range rule.
// -----------------------------------------------------------------------------
module tb_mod_mul_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance stimulus and observation arrays (index = instance).
    logic       d_valid [3];
    logic       d_rdy   [3];
    logic [7:0] d_a     [3];
    logic [7:0] d_b     [3];
    logic       o_rdy   [3];
    logic       o_vld   [3];
    logic       o_err   [3];
    logic [7:0] o_z     [3];

    mod_mul_seq_if #(.W(6)) if0 ();
    mod_mul_seq_if #(.W(6)) if1 ();
    mod_mul_seq_if #(.W(8)) if2 ();

    assign if0.in_valid  = d_valid[0];
    assign if0.in_a      = d_a[0][5:0];
    assign if0.in_b      = d_b[0][5:0];
    assign if0.out_ready = d_rdy[0];
    assign o_rdy[0]      = if0.in_ready;
    assign o_vld[0]      = if0.out_valid;
    assign o_err[0]      = if0.out_err;
    assign o_z[0]        = {2'b00, if0.out_z};

    assign if1.in_valid  = d_valid[1];
    assign if1.in_a      = d_a[1][5:0];
    assign if1.in_b      = d_b[1][5:0];
    assign if1.out_ready = d_rdy[1];
    assign o_rdy[1]      = if1.in_ready;
    assign o_vld[1]      = if1.out_valid;
    assign o_err[1]      = if1.out_err;
    assign o_z[1]        = {2'b00, if1.out_z};

    assign if2.in_valid  = d_valid[2];
    assign if2.in_a      = d_a[2];
    assign if2.in_b      = d_b[2];
    assign if2.out_ready = d_rdy[2];
    assign o_rdy[2]      = if2.in_ready;
    assign o_vld[2]      = if2.out_valid;
    assign o_err[2]      = if2.out_err;
    assign o_z[2]        = if2.out_z;

    mod_mul_seq #(.MOD(53), .W(6), .USE_CONST(1), .CONST_B(13)) u_dut_const (
        .clk (clk), .rst_n (rst_n), .bus (if0)
    );
    mod_mul_seq #(.MOD(53), .W(6), .USE_CONST(0), .CONST_B(13)) u_dut_rt53 (
        .clk (clk), .rst_n (rst_n), .bus (if1)
    );
    mod_mul_seq #(.MOD(251), .W(8), .USE_CONST(0), .CONST_B(13)) u_dut_rt251 (
        .clk (clk), .rst_n (rst_n), .bus (if2)
    );

    // ---------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------
    function automatic int mod_of(input int s);
        return (s == 2) ? 251 : 53;
    endfunction

    function automatic int w_of(input int s);
        return (s == 2) ? 8 : 6;
    endfunction

    function automatic bit exp_err(input int s, input int a, input int b);
        return (a >= mod_of(s)) || ((s != 0) && (b >= mod_of(s)));
    endfunction

    function automatic int exp_z(input int s, input int a, input int b);
        int bb;
        bb = (s == 0) ? 13 : b;
        if (exp_err(s, a, b)) return 0;
        return (a * bb) % mod_of(s);
    endfunction

    // ---------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Job helpers. Inputs change 1 time unit after a rising edge and
    // outputs are sampled 1-2 units later, well clear of the next edge.
    // ---------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int s, input int a, input int b);
        int n;
        n = 0;
        d_a[s]     = 8'(a);
        d_b[s]     = 8'(b);
        d_valid[s] = 1'b1;
        #1;
        while (!o_rdy[s] && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("in_ready_at_accept", 32'(o_rdy[s]), 32'd1);
        @(posedge clk);
        #1;
        // Operands must have been captured on the accept edge only.
        d_valid[s] = 1'b0;
        d_a[s]     = 8'($urandom);
        d_b[s]     = 8'($urandom);
    endtask

    task automatic wait_result(input int s, input int a, input int b);
        int n;
        n = 0;
        while (!o_vld[s] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latency", 32'(n), 32'(w_of(s)));
        check_eq("out_z", 32'(o_z[s]), 32'(exp_z(s, a, b)));
        check_eq("out_err", 32'(o_err[s]), 32'(exp_err(s, a, b)));
    endtask

    task automatic hold_check(input int s, input int a, input int b, input int cycles);
        repeat (cycles) begin
            tick();
            check_eq("stall_valid", 32'(o_vld[s]), 32'd1);
            check_eq("stall_z", 32'(o_z[s]), 32'(exp_z(s, a, b)));
            check_eq("stall_in_ready", 32'(o_rdy[s]), 32'd0);
        end
    endtask

    task automatic finish_job(input int s);
        d_rdy[s] = 1'b1;
        #1;
        check_eq("in_ready_done_ready", 32'(o_rdy[s]), 32'd1);
        @(posedge clk);
        #1;
        d_rdy[s] = 1'b0;
        #1;
        check_eq("valid_released", 32'(o_vld[s]), 32'd0);
    endtask

    task automatic run_job(input int s, input int a, input int b, input int stall);
        start_job(s, a, b);
        wait_result(s, a, b);
        hold_check(s, a, b, stall);
        finish_job(s);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    // ---------------------------------------------------------------
    // Watchdog
    // ---------------------------------------------------------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 3000000", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            d_valid[s] = 1'b0;
            d_rdy[s]   = 1'b0;
            d_a[s]     = '0;
            d_b[s]     = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check_eq("reset_out_valid", 32'(o_vld[s]), 32'd0);
            check_eq("reset_out_z", 32'(o_z[s]), 32'd0);
            check_eq("reset_out_err", 32'(o_err[s]), 32'd0);
            check_eq("reset_in_ready", 32'(o_rdy[s]), 32'd1);
        end
        rst_n = 1'b1;
        tick();

        // Constant multiplier K=13 mod 53, including an out-of-range a.
        run_job(0, 1, 0, 0);
        run_job(0, 5, 63, 1);
        run_job(0, 52, 17, 0);
        run_job(0, 53, 0, 0);

        // Runtime multiplier mod 53, including an out-of-range b.
        run_job(1, 52, 52, 0);
        run_job(1, 0, 37, 0);
        run_job(1, 17, 1, 2);
        run_job(1, 5, 60, 0);

        // Backpressure for 10 cycles, then back-to-back accept on the
        // result handshake edge.
        start_job(1, 7, 9);
        wait_result(1, 7, 9);
        hold_check(1, 7, 9, 10);
        d_a[1]     = 8'd30;
        d_b[1]     = 8'd40;
        d_valid[1] = 1'b1;
        #1;
        check_eq("b2b_in_ready_stalled", 32'(o_rdy[1]), 32'd0);
        d_rdy[1] = 1'b1;
        #1;
        check_eq("b2b_in_ready_open", 32'(o_rdy[1]), 32'd1);
        @(posedge clk);
        #1;
        d_valid[1] = 1'b0;
        d_rdy[1]   = 1'b0;
        d_a[1]     = 8'($urandom);
        d_b[1]     = 8'($urandom);
        #1;
        check_eq("b2b_valid_dropped", 32'(o_vld[1]), 32'd0);
        check_eq("b2b_busy_in_ready", 32'(o_rdy[1]), 32'd0);
        wait_result(1, 30, 40);
        finish_job(1);

        // Reset while BUSY with count at 3: drops to IDLE without an edge.
        start_job(1, 20, 30);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy_valid", 32'(o_vld[1]), 32'd0);
        check_eq("rst_busy_in_ready", 32'(o_rdy[1]), 32'd1);
        #2;
        rst_n = 1'b1;
        tick();

        // Reset while holding a result in DONE.
        start_job(1, 20, 30);
        wait_result(1, 20, 30);
        rst_n = 1'b0;
        #1;
        check_eq("rst_done_valid", 32'(o_vld[1]), 32'd0);
        check_eq("rst_done_z", 32'(o_z[1]), 32'd0);
        check_eq("rst_done_in_ready", 32'(o_rdy[1]), 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        run_job(1, 17, 1, 0);
        run_job(1, 44, 23, 0);

        // Full operand sweep mod 53 with random result stalls and gaps.
        for (int a = 0; a < 53; a++) begin
            for (int b = 0; b < 53; b++) begin
                run_job(1, a, b, int'($urandom_range(0, 2)));
            end
        end

        // Constant mode over random 6-bit multiplicands.
        for (int i = 0; i < 64; i++) begin
            run_job(0, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 1)));
        end

        // Modulus 251, width 8: random pairs (a few land in the error range).
        for (int i = 0; i < 400; i++) begin
            run_job(2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 2)));
        end
        run_job(2, 250, 250, 0);
        run_job(2, 251, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
